// File: rtl/m_dram_arbiter.sv
// Two-master round-robin arbiter for the single DRAM port: one transaction at a time,
// with a watchdog that forces completion when the DRAM never drops busy.
module m_dram_arbiter #(
  parameter int TIMEOUT = 4096,
  parameter int TW      = 13
) (
  input  logic        CLK,
  input  logic        RST_X,
  input  logic        w_req0,
  input  logic [31:0] w_addr0,
  input  logic [31:0] w_wdata0,
  input  logic        w_we0,
  input  logic [2:0]  w_ctrl0,
  output logic        w_ack0,
  output logic [31:0] w_rdata0,
  input  logic        w_req1,
  input  logic [31:0] w_addr1,
  input  logic [31:0] w_wdata1,
  input  logic        w_we1,
  input  logic [2:0]  w_ctrl1,
  output logic        w_ack1,
  output logic [31:0] w_rdata1,
  output logic [31:0] w_dram_addr,
  output logic [31:0] w_dram_wdata,
  output logic [2:0]  w_dram_ctrl,
  output logic        w_dram_we_t,
  output logic        w_dram_le,
  input  logic [31:0] w_dram_odata,
  input  logic        w_dram_busy,
  output logic        w_timeout,
  output logic [1:0]  w_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT - 1);

  state_t      state;
  logic        gnt;
  logic        last_gnt;
  logic        we_r;
  logic        seen_busy;
  logic [TW-1:0] wdog;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [2:0]  ctrl_r;

  logic        pick;
  logic        finish;
  logic        expired;
  logic        issue_ok;
  logic [31:0] ret_data;

  // Handshake: the DRAM takes a command in a cycle where a strobe is high and
  // busy is low; busy rises the next cycle and read data is valid when it falls.
  assign issue_ok     = (state == S_ISSUE) && !w_dram_busy;
  assign w_dram_le    = issue_ok && !we_r;
  assign w_dram_we_t  = issue_ok && we_r;
  assign w_dram_addr  = addr_r;
  assign w_dram_wdata = wdata_r;
  assign w_dram_ctrl  = ctrl_r;
  assign w_dbg_state  = state;

  // With both masters requesting, the one not served last time wins.
  always_comb begin
    pick = w_req1;
    if (w_req0 && w_req1) pick = ~last_gnt;
  end

  // Completion needs busy to have been seen high first, unless the watchdog
  // runs out; only a still-high busy at expiry counts as a stuck DRAM.
  always_comb begin
    finish   = 1'b0;
    expired  = 1'b0;
    ret_data = w_dram_odata;
    if (state == S_WAIT) begin
      if (seen_busy && !w_dram_busy) begin
        finish = 1'b1;
      end else if (wdog == WD_LAST) begin
        finish  = 1'b1;
        expired = w_dram_busy;
        if (w_dram_busy) ret_data = 32'hFFFF_FFFF;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state     <= S_IDLE;
      gnt       <= 1'b0;
      last_gnt  <= 1'b1;
      we_r      <= 1'b0;
      seen_busy <= 1'b0;
      wdog      <= '0;
      addr_r    <= '0;
      wdata_r   <= '0;
      ctrl_r    <= '0;
      w_ack0    <= 1'b0;
      w_ack1    <= 1'b0;
      w_rdata0  <= '0;
      w_rdata1  <= '0;
      w_timeout <= 1'b0;
    end else begin
      w_ack0 <= 1'b0;
      w_ack1 <= 1'b0;
      case (state)
        S_IDLE: begin
          if (w_req0 || w_req1) begin
            gnt     <= pick;
            addr_r  <= pick ? w_addr1  : w_addr0;
            wdata_r <= pick ? w_wdata1 : w_wdata0;
            we_r    <= pick ? w_we1    : w_we0;
            ctrl_r  <= pick ? w_ctrl1  : w_ctrl0;
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!w_dram_busy) begin
            state     <= S_WAIT;
            wdog      <= '0;
            seen_busy <= 1'b0;
          end
        end
        S_WAIT: begin
          wdog <= wdog + 1'b1;
          if (w_dram_busy) seen_busy <= 1'b1;
          if (finish) begin
            state <= S_DONE;
            if (expired) w_timeout <= 1'b1;
            if (gnt) w_ack1 <= 1'b1;
            else     w_ack0 <= 1'b1;
            if (!we_r) begin
              if (gnt) w_rdata1 <= ret_data;
              else     w_rdata0 <= ret_data;
            end
          end
        end
        S_DONE: begin
          last_gnt <= gnt;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_m_dram_arbiter.sv
// Directed bench for m_dram_arbiter: behavioural DRAM model, scoreboard queues
// for issued commands and acks, per-cycle checks of held outputs.
module tb_m_dram_arbiter;

  localparam int TIMEOUT = 20;
  localparam int TW      = 5;

  logic        CLK = 1'b0;
  logic        RST_X = 1'b0;
  logic        w_req0 = 0, w_req1 = 0;
  logic [31:0] w_addr0 = 0, w_addr1 = 0, w_wdata0 = 0, w_wdata1 = 0;
  logic        w_we0 = 0, w_we1 = 0;
  logic [2:0]  w_ctrl0 = 0, w_ctrl1 = 0;
  logic        w_ack0, w_ack1;
  logic [31:0] w_rdata0, w_rdata1;
  logic [31:0] w_dram_addr, w_dram_wdata;
  logic [2:0]  w_dram_ctrl;
  logic        w_dram_we_t, w_dram_le;
  logic [31:0] w_dram_odata = 0;
  logic        w_dram_busy = 0;
  logic        w_timeout;
  logic [1:0]  w_dbg_state;

  m_dram_arbiter #(.TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .CLK(CLK), .RST_X(RST_X),
    .w_req0(w_req0), .w_addr0(w_addr0), .w_wdata0(w_wdata0), .w_we0(w_we0),
    .w_ctrl0(w_ctrl0), .w_ack0(w_ack0), .w_rdata0(w_rdata0),
    .w_req1(w_req1), .w_addr1(w_addr1), .w_wdata1(w_wdata1), .w_we1(w_we1),
    .w_ctrl1(w_ctrl1), .w_ack1(w_ack1), .w_rdata1(w_rdata1),
    .w_dram_addr(w_dram_addr), .w_dram_wdata(w_dram_wdata), .w_dram_ctrl(w_dram_ctrl),
    .w_dram_we_t(w_dram_we_t), .w_dram_le(w_dram_le), .w_dram_odata(w_dram_odata),
    .w_dram_busy(w_dram_busy), .w_timeout(w_timeout), .w_dbg_state(w_dbg_state)
  );

  // Clock / reset
  always #5 CLK = ~CLK;

  // Scoreboard state
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_ack_cyc = 0;
  int strobe_cnt = 0;
  logic [67:0] exp_cmd_q[$];   // {we, ctrl, addr, wdata}
  logic [34:0] exp_ack_q[$];   // {expire, master, we, rdata}
  logic [31:0] mod_rd0 = 0, mod_rd1 = 0;
  logic        exp_timeout = 0;

  // DRAM model
  int   busy_len = 1;
  int   busy_cnt = 0;
  int   ext_busy = 0;
  bit   stuck = 0;
  logic cmd_seen = 0;
  logic [31:0] cmd_addr = 0;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a == 32'h8000_1000) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_5A5A);
  endfunction

  always @(negedge CLK) begin
    cmd_seen = w_dram_le | w_dram_we_t;
    if (cmd_seen) cmd_addr = w_dram_addr;
  end

  always @(posedge CLK) begin
    #1;
    if (ext_busy > 0) begin
      w_dram_busy = 1'b1;
      ext_busy--;
    end else if (cmd_seen) begin
      busy_cnt     = busy_len;
      w_dram_busy  = 1'b1;
      w_dram_odata = 32'hBAD0_BAD0;
    end else if (stuck) begin
      w_dram_busy = w_dram_busy;
    end else if (busy_cnt > 1) begin
      busy_cnt--;
    end else if (w_dram_busy) begin
      busy_cnt     = 0;
      w_dram_busy  = 1'b0;
      w_dram_odata = mem_val(cmd_addr);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_chk();
    chk("rst_rdata0", w_rdata0, 0);
    chk("rst_rdata1", w_rdata1, 0);
    chk("rst_dram_addr", w_dram_addr, 0);
    chk("rst_dram_wdata", w_dram_wdata, 0);
    chk("rst_misc", {w_ack0, w_ack1, w_dram_le, w_dram_we_t, w_dram_ctrl, w_timeout, w_dbg_state}, 0);
  endtask

  // One cycle of monitoring, sampled at the falling edge.
  task automatic step();
    logic [67:0] c;
    logic [34:0] a;
    @(negedge CLK);
    cyc++;
    if (w_dram_le | w_dram_we_t) begin
      strobe_cnt++;
      chk("strobe_onehot", w_dram_le ^ w_dram_we_t, 1);
      chk("strobe_busy_low", w_dram_busy, 0);
      chk("strobe_expected", 64'(exp_cmd_q.size() > 0), 1);
      if (exp_cmd_q.size() > 0) begin
        c = exp_cmd_q.pop_front();
        chk("cmd_we_ctrl", {w_dram_we_t, w_dram_ctrl}, c[67:64]);
        chk("cmd_addr", w_dram_addr, c[63:32]);
        chk("cmd_wdata", w_dram_wdata, c[31:0]);
      end
    end
    if (w_ack0 | w_ack1) begin
      last_ack_cyc = cyc;
      chk("ack_onehot", w_ack0 & w_ack1, 0);
      chk("ack_expected", 64'(exp_ack_q.size() > 0), 1);
      if (exp_ack_q.size() > 0) begin
        a = exp_ack_q.pop_front();
        chk("ack_master", w_ack1, a[33]);
        if (a[34]) exp_timeout = 1'b1;
        if (!a[32]) begin
          if (a[33]) mod_rd1 = a[31:0];
          else       mod_rd0 = a[31:0];
        end
      end
      if (w_ack0) w_req0 = 1'b0;
      if (w_ack1) w_req1 = 1'b0;
    end
    chk("rdata0", w_rdata0, mod_rd0);
    chk("rdata1", w_rdata1, mod_rd1);
    chk("timeout_flag", w_timeout, exp_timeout);
  endtask

  // Driver: raise a request and record what the arbiter must do with it.
  task automatic issue(input bit m, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [2:0] ctrl, input bit expire);
    logic [31:0] rd;
    if (m) begin
      w_req1 = 1; w_we1 = we; w_addr1 = addr; w_wdata1 = wdata; w_ctrl1 = ctrl;
    end else begin
      w_req0 = 1; w_we0 = we; w_addr0 = addr; w_wdata0 = wdata; w_ctrl0 = ctrl;
    end
    rd = expire ? 32'hFFFF_FFFF : mem_val(addr);
    exp_cmd_q.push_back({we, ctrl, addr, wdata});
    exp_ack_q.push_back({expire, m, we, rd});
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_ack_q.size() > 0 && n < budget) begin
      step();
      n++;
    end
    chk("drain_in_time", 64'(exp_ack_q.size()), 0);
    chk("cmds_consumed", 64'(exp_cmd_q.size()), 0);
    step();
  endtask

  initial begin
    int start, s0, n;
    #12;
    reset_chk();
    step();
    step();
    RST_X = 1'b1;
    step();

    // Contention right after reset, M0 reading 0x80001000 with 3 busy cycles.
    busy_len = 3;
    issue(0, 0, 32'h8000_1000, 32'h0, 3'b010, 0);
    issue(1, 0, 32'h8000_1100, 32'h0, 3'b010, 0);
    drain(40);
    chk("single_read_data", w_rdata0, 32'hDEAD_BEEF);

    // Minimum latency with 1-cycle busy.
    busy_len = 1;
    start = cyc;
    issue(0, 0, 32'h8000_0040, 32'h0, 3'b010, 0);
    drain(20);
    chk("min_latency", 64'(last_ack_cyc - start), 4);

    // M0 served last, so simultaneous requests go to M1 first.
    issue(1, 0, 32'h8000_0200, 32'h0, 3'b001, 0);
    issue(0, 0, 32'h8000_0300, 32'h0, 3'b000, 0);
    drain(40);

    // M1 write, SW size; its rdata must stay put.
    issue(1, 1, 32'h8000_2000, 32'h1234_5678, 3'b010, 0);
    drain(20);

    // Busy held high as the arbiter reaches ISSUE.
    s0 = strobe_cnt;
    ext_busy = 5;
    issue(0, 0, 32'h8000_0500, 32'h0, 3'b010, 0);
    repeat (4) step();
    chk("hold_issue_state", w_dbg_state, 2'd1);
    chk("no_strobe_while_busy", 64'(strobe_cnt - s0), 0);
    drain(30);
    chk("one_strobe_after_busy", 64'(strobe_cnt - s0), 1);

    // Watchdog: busy stuck high after issue.
    stuck = 1;
    s0 = strobe_cnt;
    issue(1, 0, 32'h8000_0600, 32'h0, 3'b010, 1);
    n = 0;
    while (strobe_cnt == s0 && n < 10) begin
      step();
      n++;
    end
    chk("wd_strobe_seen", 64'(strobe_cnt - s0), 1);
    repeat (TIMEOUT) step();
    chk("wd_not_early", 64'(exp_ack_q.size()), 1);
    step();
    chk("wd_ack_on_time", 64'(exp_ack_q.size()), 0);
    stuck = 0;
    drain(10);
    issue(0, 1, 32'h8000_0700, 32'hCAFE_0001, 3'b010, 0);
    drain(20);

    // Random transactions.
    for (int i = 0; i < 6; i++) begin
      busy_len = $urandom_range(1, 4);
      issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            {16'h8000, 16'($urandom_range(0, 16'hFFFF))}, $urandom, 3'($urandom_range(0, 7)), 0);
      drain(30);
    end

    // Reset in the middle of WAIT abandons the transaction.
    busy_len = 8;
    issue(0, 0, 32'h8000_0800, 32'h0, 3'b010, 0);
    n = 0;
    while (w_dbg_state != 2'd2 && n < 10) begin
      step();
      n++;
    end
    chk("reached_wait", w_dbg_state, 2'd2);
    RST_X = 1'b0;
    #1;
    reset_chk();
    exp_cmd_q.delete();
    exp_ack_q.delete();
    mod_rd0 = 0;
    mod_rd1 = 0;
    exp_timeout = 0;
    w_req0 = 0;
    busy_cnt = 0;
    stuck = 0;
    repeat (3) step();
    RST_X = 1'b1;
    step();
    busy_len = 2;
    issue(1, 0, 32'h8000_0900, 32'h0, 3'b010, 0);
    drain(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
